// File: rtl/jls_pkg.sv
// JPEG-LS context generator shared package: default thresholds,
// quantised-gradient width and the gradient quantiser function.
package jls_pkg;

  localparam int QW = 4;
  localparam int T1_DEF = 3;
  localparam int T2_DEF = 7;
  localparam int T3_DEF = 21;

  function automatic logic signed [QW-1:0] gradient_q(
    input int d,
    input int t1,
    input int t2,
    input int t3
  );
    logic signed [QW-1:0] q;
    if (d <= -t3)      q = QW'(-4);
    else if (d <= -t2) q = QW'(-3);
    else if (d <= -t1) q = QW'(-2);
    else if (d < 0)    q = QW'(-1);
    else if (d == 0)   q = QW'(0);
    else if (d < t1)   q = QW'(1);
    else if (d < t2)   q = QW'(2);
    else if (d < t3)   q = QW'(3);
    else               q = QW'(4);
    return q;
  endfunction

endpackage

// File: rtl/jls_context_gen_if.sv
// Pixel-in / context-out stream bundle for jls_context_gen.
// slave: block side (pixels in, context out); master: source/sink side.
interface jls_context_gen_if
  import jls_pkg::*;
#(
  parameter int PIX_W = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_sof;
  logic [PIX_W-1:0]        s_pix;
  logic                    m_valid;
  logic                    m_ready;
  logic [PIX_W-1:0]        m_x;
  logic [PIX_W-1:0]        m_ra;
  logic [PIX_W-1:0]        m_rb;
  logic [PIX_W-1:0]        m_rc;
  logic [PIX_W-1:0]        m_rd;
  logic signed [PIX_W:0]   m_d1;
  logic signed [PIX_W:0]   m_d2;
  logic signed [PIX_W:0]   m_d3;
  logic signed [QW-1:0]    m_q1;
  logic signed [QW-1:0]    m_q2;
  logic signed [QW-1:0]    m_q3;
  logic                    m_sof;
  logic                    m_eol;
  logic                    m_eof;

  modport slave (
    input  s_valid, s_sof, s_pix, m_ready,
    output s_ready, m_valid,
    output m_x, m_ra, m_rb, m_rc, m_rd,
    output m_d1, m_d2, m_d3,
    output m_q1, m_q2, m_q3,
    output m_sof, m_eol, m_eof
  );

  modport master (
    output s_valid, s_sof, s_pix, m_ready,
    input  s_ready, m_valid,
    input  m_x, m_ra, m_rb, m_rc, m_rd,
    input  m_d1, m_d2, m_d3,
    input  m_q1, m_q2, m_q3,
    input  m_sof, m_eol, m_eof
  );

endinterface

// File: rtl/jls_grad_quant.sv
// Combinational gradient quantiser: signed D -> Q in -4..4.
// Ports: d (signed DW bits) in, q (signed QW bits) out.
module jls_grad_quant
  import jls_pkg::*;
#(
  parameter int DW = 17,
  parameter int T1 = T1_DEF,
  parameter int T2 = T2_DEF,
  parameter int T3 = T3_DEF
) (
  input  logic signed [DW-1:0] d,
  output logic signed [QW-1:0] q
);

  assign q = gradient_q(int'(d), T1, T2, T3);

endmodule

// File: rtl/jls_context_gen.sv
// Streaming JPEG-LS causal context generator (Ra/Rb/Rc/Rd, D1..3, Q1..3).
// Ports: clk, rst (sync, active-high), bus (jls_context_gen_if.slave).
module jls_context_gen
  import jls_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int IMG_W = 11,
  parameter int IMG_H = 9,
  parameter int T1    = T1_DEF,
  parameter int T2    = T2_DEF,
  parameter int T3    = T3_DEF
) (
  input  logic             clk,
  input  logic             rst,
  jls_context_gen_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] c;
  logic [CW-1:0] cn;
  logic [RW-1:0] r;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic          row0;
  logic          c0;
  logic          accept;

  logic [PIX_W-1:0] lb [IMG_W];
  logic [PIX_W-1:0] prev_pix;
  logic [PIX_W-1:0] rb_prev;
  logic [PIX_W-1:0] ra_c0;

  logic [PIX_W-1:0] ra;
  logic [PIX_W-1:0] rb;
  logic [PIX_W-1:0] rc;
  logic [PIX_W-1:0] rd;

  logic signed [PIX_W:0]  d1;
  logic signed [PIX_W:0]  d2;
  logic signed [PIX_W:0]  d3;
  logic signed [QW-1:0]   q1;
  logic signed [QW-1:0]   q2;
  logic signed [QW-1:0]   q3;

  logic                   vld;
  logic [PIX_W-1:0]       x_r;
  logic [PIX_W-1:0]       ra_r;
  logic [PIX_W-1:0]       rb_r;
  logic [PIX_W-1:0]       rc_r;
  logic [PIX_W-1:0]       rd_r;
  logic signed [PIX_W:0]  d1_r;
  logic signed [PIX_W:0]  d2_r;
  logic signed [PIX_W:0]  d3_r;
  logic signed [QW-1:0]   q1_r;
  logic signed [QW-1:0]   q2_r;
  logic signed [QW-1:0]   q3_r;
  logic                   sof_r;
  logic                   eol_r;
  logic                   eof_r;

  assign bus.s_ready = !rst && (!vld || bus.m_ready);
  assign accept      = bus.s_valid && bus.s_ready;

  // s_sof forces position (0,0) regardless of the counters
  assign c    = bus.s_sof ? '0 : col;
  assign r    = bus.s_sof ? '0 : row;
  assign row0 = (r == '0);
  assign c0   = (c == '0);
  assign cn   = (c == CMAX) ? c : c + 1'b1;

  // Line buffer is read before this pixel overwrites slot c, so
  // lb[c] and lb[c+1] still hold the prior line. lb[c-1] is already
  // the current line, hence Rc comes from the Rb used one pixel ago.
  always_comb begin
    ra = '0;
    rb = '0;
    rc = '0;
    rd = '0;
    if (!row0) begin
      rb = lb[c];
      rd = lb[cn];
      if (c0) begin
        ra = lb[c];
        rc = ra_c0;
      end else begin
        ra = prev_pix;
        rc = rb_prev;
      end
    end else if (!c0) begin
      ra = prev_pix;
    end
  end

  assign d1 = $signed({1'b0, rd}) - $signed({1'b0, rb});
  assign d2 = $signed({1'b0, rb}) - $signed({1'b0, rc});
  assign d3 = $signed({1'b0, rc}) - $signed({1'b0, ra});

  jls_grad_quant #(
    .DW(PIX_W + 1), .T1(T1), .T2(T2), .T3(T3)
  ) u_q1 (
    .d(d1), .q(q1)
  );

  jls_grad_quant #(
    .DW(PIX_W + 1), .T1(T1), .T2(T2), .T3(T3)
  ) u_q2 (
    .d(d2), .q(q2)
  );

  jls_grad_quant #(
    .DW(PIX_W + 1), .T1(T1), .T2(T2), .T3(T3)
  ) u_q3 (
    .d(d3), .q(q3)
  );

  always_comb begin
    col_nxt = c + 1'b1;
    row_nxt = r;
    if (c == CMAX) begin
      col_nxt = '0;
      row_nxt = (r == RMAX) ? '0 : r + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[c] <= bus.s_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      prev_pix <= '0;
      rb_prev  <= '0;
      ra_c0    <= '0;
      vld      <= 1'b0;
      x_r      <= '0;
      ra_r     <= '0;
      rb_r     <= '0;
      rc_r     <= '0;
      rd_r     <= '0;
      d1_r     <= '0;
      d2_r     <= '0;
      d3_r     <= '0;
      q1_r     <= '0;
      q2_r     <= '0;
      q3_r     <= '0;
      sof_r    <= 1'b0;
      eol_r    <= 1'b0;
      eof_r    <= 1'b0;
    end else if (accept) begin
      col      <= col_nxt;
      row      <= row_nxt;
      prev_pix <= bus.s_pix;
      rb_prev  <= rb;
      if (c0) begin
        ra_c0 <= ra;
      end
      vld      <= 1'b1;
      x_r      <= bus.s_pix;
      ra_r     <= ra;
      rb_r     <= rb;
      rc_r     <= rc;
      rd_r     <= rd;
      d1_r     <= d1;
      d2_r     <= d2;
      d3_r     <= d3;
      q1_r     <= q1;
      q2_r     <= q2;
      q3_r     <= q3;
      sof_r    <= row0 && c0;
      eol_r    <= (c == CMAX);
      eof_r    <= (c == CMAX) && (r == RMAX);
    end else if (bus.m_ready) begin
      vld <= 1'b0;
    end
  end

  assign bus.m_valid = vld;
  assign bus.m_x     = x_r;
  assign bus.m_ra    = ra_r;
  assign bus.m_rb    = rb_r;
  assign bus.m_rc    = rc_r;
  assign bus.m_rd    = rd_r;
  assign bus.m_d1    = d1_r;
  assign bus.m_d2    = d2_r;
  assign bus.m_d3    = d3_r;
  assign bus.m_q1    = q1_r;
  assign bus.m_q2    = q2_r;
  assign bus.m_q3    = q3_r;
  assign bus.m_sof   = sof_r;
  assign bus.m_eol   = eol_r;
  assign bus.m_eof   = eof_r;

endmodule

// File: tb/tb_jls_context_gen.sv
// Self-checking bench for jls_context_gen (PIX_W=8, 4x3 frames).
// Image-level reference model plus randomized handshake stimulus.
module tb_jls_context_gen;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  jls_context_gen_if #(.PIX_W(8)) bus ();

  jls_context_gen #(
    .PIX_W(8), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rc;
    logic [7:0] rd;
    logic [8:0] d1;
    logic [8:0] d2;
    logic [8:0] d3;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic       sof;
    logic       eol;
    logic       eof;
  } ctx_t;

  ctx_t q[$];
  int   img[H][W];
  int   mr = 0;
  int   mc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qnt(input int d);
    if (d <= -21) return -4;
    if (d <= -7)  return -3;
    if (d <= -3)  return -2;
    if (d < 0)    return -1;
    if (d == 0)   return 0;
    if (d < 3)    return 1;
    if (d < 7)    return 2;
    if (d < 21)   return 3;
    return 4;
  endfunction

  // Neighbours straight from the raster image of the current frame
  function automatic ctx_t predict(input int pix);
    ctx_t e;
    int ra, rb, rc, rd;
    if (mr == 0) begin
      rb = 0;
      rc = 0;
      rd = 0;
      ra = (mc == 0) ? 0 : img[0][mc-1];
    end else if (mc == 0) begin
      ra = img[mr-1][0];
      rb = ra;
      rc = (mr == 1) ? 0 : img[mr-2][0];
      rd = img[mr-1][1];
    end else begin
      ra = img[mr][mc-1];
      rb = img[mr-1][mc];
      rc = img[mr-1][mc-1];
      rd = (mc == W-1) ? img[mr-1][mc] : img[mr-1][mc+1];
    end
    e.x   = 8'(pix);
    e.ra  = 8'(ra);
    e.rb  = 8'(rb);
    e.rc  = 8'(rc);
    e.rd  = 8'(rd);
    e.d1  = 9'(rd - rb);
    e.d2  = 9'(rb - rc);
    e.d3  = 9'(rc - ra);
    e.q1  = 4'(qnt(rd - rb));
    e.q2  = 4'(qnt(rb - rc));
    e.q3  = 4'(qnt(rc - ra));
    e.sof = (mr == 0 && mc == 0);
    e.eol = (mc == W-1);
    e.eof = (mc == W-1 && mr == H-1);
    return e;
  endfunction

  task automatic model_accept(input int pix, input logic sof);
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    q.push_back(predict(pix));
    img[mr][mc] = pix;
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
  endtask

  task automatic check_front();
    ctx_t e;
    e = q[0];
    check("m_x",   32'(bus.m_x),  32'(e.x));
    check("m_ra",  32'(bus.m_ra), 32'(e.ra));
    check("m_rb",  32'(bus.m_rb), 32'(e.rb));
    check("m_rc",  32'(bus.m_rc), 32'(e.rc));
    check("m_rd",  32'(bus.m_rd), 32'(e.rd));
    check("m_d1",  32'($unsigned(bus.m_d1)), 32'(e.d1));
    check("m_d2",  32'($unsigned(bus.m_d2)), 32'(e.d2));
    check("m_d3",  32'($unsigned(bus.m_d3)), 32'(e.d3));
    check("m_q1",  32'($unsigned(bus.m_q1)), 32'(e.q1));
    check("m_q2",  32'($unsigned(bus.m_q2)), 32'(e.q2));
    check("m_q3",  32'($unsigned(bus.m_q3)), 32'(e.q3));
    check("m_sof", 32'(bus.m_sof), 32'(e.sof));
    check("m_eol", 32'(bus.m_eol), 32'(e.eol));
    check("m_eof", 32'(bus.m_eof), 32'(e.eof));
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.m_valid), 32'(0));
    check({tag, "_x"},   32'(bus.m_x),  32'(0));
    check({tag, "_r"},
          32'({bus.m_ra, bus.m_rb, bus.m_rc, bus.m_rd}), 32'(0));
    check({tag, "_d"},
          32'($unsigned({bus.m_d1, bus.m_d2, bus.m_d3})), 32'(0));
    check({tag, "_q"},
          32'($unsigned({bus.m_q1, bus.m_q2, bus.m_q3})), 32'(0));
    check({tag, "_flags"},
          32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'(0));
  endtask

  // One clock: check outputs, drive inputs, update model
  task automatic cycle(input logic v, input int pix, input logic sof,
                       input logic rdy, input logic r);
    logic exp_ready;
    @(negedge clk);
    check("m_valid", 32'(bus.m_valid), 32'(q.size() > 0));
    if (q.size() > 0) check_front();
    bus.s_valid = v;
    bus.s_pix   = 8'(pix);
    bus.s_sof   = sof;
    bus.m_ready = rdy;
    rst         = r;
    #1;
    exp_ready = !r && (q.size() == 0 || rdy);
    check("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    if (r) begin
      q.delete();
      mr = 0;
      mc = 0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && exp_ready) model_accept(pix, sof);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic raster_frame();
    for (int i = 0; i < W*H; i++) begin
      cycle(1'b1, i + 1, i == 0, 1'b1, 1'b0);
    end
  endtask

  int ext_frame[W*H] = '{0, 255, 0, 255,
                         255, 0, 255, 0,
                         100, 103, 96, 121};

  initial begin
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_pix   = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    check_zero("rst");
    rst = 1'b0;

    raster_frame();
    raster_frame();
    idle(2);

    for (int i = 0; i < W*H; i++) begin
      cycle(1'b1, 200 - 3*i, i == 0, 1'b1, 1'b0);
      if (i == 5) begin
        for (int k = 0; k < 3; k++) cycle(1'b1, 77, 1'b0, 1'b0, 1'b0);
      end
    end
    idle(2);

    for (int i = 0; i < W*H; i++) begin
      cycle(1'b1, ext_frame[i], i == 0, 1'b1, 1'b0);
    end
    idle(2);

    for (int i = 0; i < 6; i++) cycle(1'b1, i + 1, i == 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    check_zero("midrst");
    raster_frame();
    idle(2);

    for (int i = 0; i < 5; i++) cycle(1'b1, 50 + i, 1'b0, 1'b1, 1'b0);
    raster_frame();
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      logic v, sof, rdy, r;
      int   pix;
      v   = ($urandom % 4) != 0;
      rdy = ($urandom % 3) != 0;
      sof = ($urandom % 40) == 0;
      r   = ($urandom % 300) == 0;
      pix = (i % 400 < 200) ? int'($urandom % 256)
                            : int'(100 + $urandom_range(0, 30));
      cycle(v, pix, sof, rdy, r);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
